// File: rtl/vram_fill_engine.sv
// Rectangle-fill engine: writes one clipped pixel per clock into the 12-bit VRAM write port.
// Optional build macro VRAM_FILL_CHECKER_EN adds a two-colour checkerboard pattern mode.
module vram_fill_engine #(
    parameter int unsigned XBITS  = 7,
    parameter int unsigned YBITS  = 7,
    parameter int unsigned ADDR_W = XBITS + YBITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [XBITS-1:0]    cmd_x,
    input  logic [YBITS-1:0]    cmd_y,
    input  logic [XBITS:0]      cmd_w,
    input  logic [YBITS:0]      cmd_h,
    input  logic [11:0]         cmd_color,
`ifdef VRAM_FILL_CHECKER_EN
    input  logic [11:0]         cmd_color2,
    input  logic                cmd_checker,
`endif
    output logic                vram_we,
    output logic [ADDR_W-1:0]   vram_addr,
    output logic [11:0]         vram_wdata,
    output logic                busy,
    output logic                done
);

    localparam int unsigned XSUM_W = XBITS + 2;
    localparam int unsigned YSUM_W = YBITS + 2;
    localparam logic [XSUM_W-1:0] XMAX = XSUM_W'(1) << XBITS;
    localparam logic [YSUM_W-1:0] YMAX = YSUM_W'(1) << YBITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [11:0]         wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XBITS-1:0]    cx_q, cx_d;
    logic [YBITS-1:0]    cy_q, cy_d;
    logic [XBITS-1:0]    x0_q, x0_d;
    logic [XBITS-1:0]    x_end_q, x_end_d;
    logic [YBITS-1:0]    y_end_q, y_end_d;
    logic [11:0]         color_q, color_d;
`ifdef VRAM_FILL_CHECKER_EN
    logic [11:0]         color2_q, color2_d;
    logic                checker_q, checker_d;
`endif

    logic [XSUM_W-1:0]   x_sum_c, x_lim_c;
    logic [YSUM_W-1:0]   y_sum_c, y_lim_c;
    logic [XBITS-1:0]    x_end_c;
    logic [YBITS-1:0]    y_end_c;
    logic                last_col_c;
    logic                last_px_c;
    logic [XBITS-1:0]    nx_c;
    logic [YBITS-1:0]    ny_c;
    logic [11:0]         first_px_c;
    logic [11:0]         next_px_c;

    // Clip bounds saturate at the framebuffer edge so addresses never wrap.
    always_comb begin
        x_sum_c = XSUM_W'(cmd_x) + XSUM_W'(cmd_w);
        y_sum_c = YSUM_W'(cmd_y) + YSUM_W'(cmd_h);
        x_lim_c = (x_sum_c > XMAX) ? XMAX : x_sum_c;
        y_lim_c = (y_sum_c > YMAX) ? YMAX : y_sum_c;
        x_end_c = XBITS'(x_lim_c - XSUM_W'(1));
        y_end_c = YBITS'(y_lim_c - YSUM_W'(1));
    end

    always_comb begin
        last_col_c = (cx_q == x_end_q);
        last_px_c  = last_col_c && (cy_q == y_end_q);
        nx_c       = last_col_c ? x0_q : cx_q + XBITS'(1);
        ny_c       = last_col_c ? cy_q + YBITS'(1) : cy_q;
    end

    // Pattern parity uses absolute framebuffer coordinates.
    always_comb begin
`ifdef VRAM_FILL_CHECKER_EN
        first_px_c = (cmd_checker && (cmd_x[0] ^ cmd_y[0])) ? cmd_color2 : cmd_color;
        next_px_c  = (checker_q && (nx_c[0] ^ ny_c[0])) ? color2_q : color_q;
`else
        first_px_c = cmd_color;
        next_px_c  = color_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            x0_q        <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            color_q     <= '0;
`ifdef VRAM_FILL_CHECKER_EN
            color2_q    <= '0;
            checker_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            x0_q        <= x0_d;
            x_end_q     <= x_end_d;
            y_end_q     <= y_end_d;
            color_q     <= color_d;
`ifdef VRAM_FILL_CHECKER_EN
            color2_q    <= color2_d;
            checker_q   <= checker_d;
`endif
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cx_d        = cx_q;
        cy_d        = cy_q;
        x0_d        = x0_q;
        x_end_d     = x_end_q;
        y_end_d     = y_end_q;
        color_d     = color_q;
`ifdef VRAM_FILL_CHECKER_EN
        color2_d    = color2_q;
        checker_d   = checker_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    cx_d        = cmd_x;
                    cy_d        = cmd_y;
                    x0_d        = cmd_x;
                    x_end_d     = x_end_c;
                    y_end_d     = y_end_c;
                    color_d     = cmd_color;
`ifdef VRAM_FILL_CHECKER_EN
                    color2_d    = cmd_color2;
                    checker_d   = cmd_checker;
`endif
                    if ((cmd_w == '0) || (cmd_h == '0)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'({cmd_y, cmd_x});
                        wdata_d = first_px_c;
                    end
                end
            end
            ST_FILL: begin
                if (last_px_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    cx_d    = nx_c;
                    cy_d    = ny_c;
                    addr_d  = ADDR_W'({ny_c, nx_c});
                    wdata_d = next_px_c;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign cmd_ready  = cmd_ready_q;
    assign vram_we    = we_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/vram_fill_engine.md
# vram_fill_engine

Rectangle-fill engine that writes solid colour into the 12-bit-per-pixel video RAM scanned out by the video generator. It drives the VRAM write port with one pixel per clock, clipped to the framebuffer. The VRAM read side is owned by the video generator, so this block only writes. It sits directly upstream of the video memory and is commanded by the CPU-side bus logic over a valid/ready handshake.

## Interface
Parameters:
- XBITS, 7, framebuffer column-address bits; framebuffer width is 2^XBITS
- YBITS, 7, framebuffer row-address bits; framebuffer height is 2^YBITS
- ADDR_W, XBITS+YBITS (14), VRAM address width

Ports:
- clk  in  1  system clock (PLL output); single clock domain
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command this cycle
- cmd_x  in  XBITS  left column
- cmd_y  in  YBITS  top row
- cmd_w  in  XBITS+1  width in pixels, 0..2^XBITS
- cmd_h  in  YBITS+1  height in pixels, 0..2^YBITS
- cmd_color  in  12  fill colour, RGB444
- vram_we  out  1  write strobe
- vram_addr  out  ADDR_W  write address = {row, col}
- vram_wdata  out  12  write data
- busy  out  1  high in FILL or DONE
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, FILL, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the command. Compute x_end = min(cmd_x+cmd_w, 2^XBITS)−1 and y_end = min(cmd_y+cmd_h, 2^YBITS)−1, each in XBITS+1 or YBITS+1 bits with saturation (clip, never wrap). Load cx=cmd_x and cy=cmd_y.
  - If cmd_w==0 or cmd_h==0, go to DONE with no writes.
  - Otherwise go to FILL.
- FILL: every cycle assert vram_we with addr={cy,cx} and wdata=colour (or the pattern colour, see Configuration).
  - If cx==x_end: cx←x0 and cy←cy+1; else cx←cx+1.
  - If cx==x_end and cy==y_end: go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- cmd_ready=0 in FILL and DONE. cmd_valid is ignored there; the upstream must hold it.
- Row-major order; exactly (x_end−x0+1)·(y_end−y0+1) writes per command, with no gaps.
- Reset at any time: state←IDLE and all outputs←0. Writes already issued remain in VRAM; the rest of the command is discarded.

## Timing
- Reset values: cmd_ready=0 while rst low, then 1 from the first cycle after release; vram_we=0, vram_addr=0, vram_wdata=0, busy=0, done=0.
- All outputs are registered.
- Command accepted at edge N: first write is valid in cycle N+1. P pixels occupy cycles N+1..N+P. done is high in cycle N+P+1. cmd_ready returns in cycle N+P+2.
- Zero-size command accepted at N: done at N+1, ready at N+2.
- Back-to-back: minimum command spacing is P+2 cycles.
- vram_addr and vram_wdata are held at their last values when vram_we=0.

## Configuration
- Macro VRAM_FILL_CHECKER_EN.
- Defined:
  - Adds input ports cmd_color2 (12 bits) and cmd_checker (1 bit), both latched at accept.
  - When cmd_checker=1, pixel data = cmd_color2 if (cx[0]^cy[0]) else cmd_color. Parity uses absolute coordinates.
  - When cmd_checker=0, output is identical to the undefined build.
- Undefined: these ports do not exist, and every pixel gets cmd_color.

## Test plan
- Reset with cmd_valid=1 held: all outputs 0 during reset; cmd_ready=1 one cycle after release; first accepted command executes normally.
- x=2, y=3, w=3, h=2, color=0xF00 → 6 writes at addresses 386,387,388,514,515,516 (decimal, {y,x}), all 0xF00, on consecutive cycles; done pulses one cycle after the last write.
- x=126, y=127, w=5, h=4 → clipped to 2 writes at addresses 16382 and 16383; no address wrap; done follows.
- w=0, h=7 → no vram_we; done at accept+1; cmd_ready at accept+2.
- Assert rst mid-fill after 3 of 6 writes → vram_we drops immediately; no further writes after release; busy=0 and done=0.
- With VRAM_FILL_CHECKER_EN defined: x=0, y=0, w=2, h=2, color=0x000, color2=0xFFF, checker=1 → data sequence 0x000, 0xFFF, 0xFFF, 0x000.
